// File: rtl/scoreboard.sv
// Sequential double-dabble converter from an 8-bit score to two BCD digits and 7-seg codes.
// Optional SCOREBOARD_LEADING_ZERO_BLANK_EN blanks the tens display when the tens digit is 0.
module scoreboard #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [7:0]  binary,
   input  logic        update,
   output logic [13:0] score,
   output logic [7:0]  BCD_score,
   output logic        completed_conversion
);

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   state_e      state_q;
   logic        update_q;
   logic [7:0]  bin_q;
   logic [7:0]  bcd_q;
   logic [3:0]  cnt_q;
   logic [7:0]  bcd_out_q;
   logic [13:0] score_q;
   logic        completed_q;
   logic        start;
   logic [7:0]  adj_d;
   logic [15:0] shift_d;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return SEG_ACTIVE_LOW ? ~s : s;
   endfunction

   function automatic logic [6:0] tens_decode(input logic [3:0] d);
`ifdef SCOREBOARD_LEADING_ZERO_BLANK_EN
      if (d == 4'd0) return SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
`endif
      return seg_decode(d);
   endfunction

   assign start = update & ~update_q;

   // Add-3 correction precedes the shift so each nibble stays a valid BCD digit.
   always_comb begin
      adj_d = bcd_q;
      if (adj_d[3:0] >= 4'd5) adj_d[3:0] = adj_d[3:0] + 4'd3;
      if (adj_d[7:4] >= 4'd5) adj_d[7:4] = adj_d[7:4] + 4'd3;
      shift_d = {adj_d[6:0], bin_q, 1'b0};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         update_q    <= 1'b0;
         bin_q       <= 8'h00;
         bcd_q       <= 8'h00;
         cnt_q       <= 4'd0;
         bcd_out_q   <= 8'h00;
         score_q     <= {tens_decode(4'd0), seg_decode(4'd0)};
         completed_q <= 1'b0;
      end else begin
         update_q    <= update;
         completed_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) state_q <= StLoad;
            end
            StLoad: begin
               bin_q   <= (binary > 8'd99) ? 8'd99 : binary;
               bcd_q   <= 8'h00;
               cnt_q   <= 4'd8;
               state_q <= StShift;
            end
            StShift: begin
               bcd_q <= shift_d[15:8];
               bin_q <= shift_d[7:0];
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= StDone;
            end
            StDone: begin
               bcd_out_q   <= bcd_q;
               score_q     <= {tens_decode(bcd_q[7:4]), seg_decode(bcd_q[3:0])};
               completed_q <= 1'b1;
               state_q     <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign score                = score_q;
   assign BCD_score            = bcd_out_q;
   assign completed_conversion = completed_q;

endmodule

// File: tb/tb_scoreboard.sv
// Self-checking bench for scoreboard: expected conversions queued at request, checked on completion.
module tb_scoreboard;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  binary;
   logic        update;
   logic [13:0] score;
   logic [7:0]  BCD_score;
   logic        completed_conversion;

   scoreboard #(.SEG_ACTIVE_LOW(1'b1)) dut (
      .clock                (clock),
      .reset                (reset),
      .binary               (binary),
      .update               (update),
      .score                (score),
      .BCD_score            (BCD_score),
      .completed_conversion (completed_conversion)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  bcd;
      logic [13:0] seg;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", tag, got, want);
      end
   endtask

   function automatic logic [6:0] model_seg(input int d);
      logic [6:0] s;
      case (d)
         0: s = 7'h3F;  1: s = 7'h06;  2: s = 7'h5B;  3: s = 7'h4F;  4: s = 7'h66;
         5: s = 7'h6D;  6: s = 7'h7D;  7: s = 7'h07;  8: s = 7'h7F;  default: s = 7'h6F;
      endcase
      return ~s;
   endfunction

   function automatic logic [13:0] model_score(input int v);
      logic [6:0] t;
      t = model_seg(v / 10);
`ifdef SCOREBOARD_LEADING_ZERO_BLANK_EN
      if (v / 10 == 0) t = 7'h7F;
`endif
      return {t, model_seg(v % 10)};
   endfunction

   function automatic exp_t make_exp(input int b, input int due);
      exp_t e;
      int v;
      v = (b > 99) ? 99 : b;
      e.bcd = 8'((v / 10) * 16 + (v % 10));
      e.seg = model_score(v);
      e.due = due;
      return e;
   endfunction

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (completed_conversion === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("bcd", {24'd0, BCD_score}, {24'd0, mon_e.bcd});
            check("seg", {18'd0, score}, {18'd0, mon_e.seg});
            check("latency", cyc, mon_e.due);
         end
      end
   end

   task automatic start_conv(input int v, input bit push);
      @(posedge clock);
      #1;
      binary = 8'(v);
      update = 1'b1;
      if (push) exp_q.push_back(make_exp(v, cyc + 11));
      @(posedge clock);
      #1 update = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clock);
      end
      if (exp_q.size() != 0) begin
         check("timeout", exp_q.size(), 0);
         exp_q.delete();
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_bcd"}, {24'd0, BCD_score}, 32'd0);
      check({tag, "_done"}, {31'd0, completed_conversion}, 32'd0);
      check({tag, "_seg"}, {18'd0, score}, {18'd0, model_score(0)});
   endtask

   initial begin
      reset  = 1'b1;
      update = 1'b0;
      binary = 8'd0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_reset_vals("reset");

      start_conv(11, 1'b1);  wait_drain();
      start_conv(7, 1'b1);   wait_drain();
      start_conv(255, 1'b1); wait_drain();
      start_conv(99, 1'b1);  wait_drain();
      start_conv(0, 1'b1);   wait_drain();
      start_conv(100, 1'b1); wait_drain();
      start_conv(42, 1'b1);  wait_drain();

      // Second request while busy must not restart or queue a conversion.
      start_conv(35, 1'b1);
      repeat (3) @(posedge clock);
      start_conv(80, 1'b0);
      wait_drain();
      repeat (15) @(negedge clock);

      // Held level: exactly one conversion.
      @(posedge clock);
      #1;
      binary = 8'd56;
      update = 1'b1;
      exp_q.push_back(make_exp(56, cyc + 11));
      repeat (20) @(posedge clock);
      #1 update = 1'b0;
      wait_drain();
      repeat (15) @(negedge clock);
      check("hold_bcd", {24'd0, BCD_score}, 32'h56);

      // Reset mid-SHIFT aborts with no completion pulse.
      start_conv(23, 1'b0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check_reset_vals("abort");
      repeat (15) @(negedge clock);

      start_conv(64, 1'b1);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
